fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the pipelined core. Owns the fetch PC and drives inst_memory's

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FAULT
  } fetch_state_e;

  typedef enum logic [1:0] {
    F_NONE,
    F_MISALIGN,
    F_RANGE
  } fetch_fault_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of {pc,inst} entries between fetch and decode.
// Flush beats push; pointers wrap naturally because QDEPTH is a power of two.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  entry,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointer and occupancy bookkeeping; a flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, feeds decode through a
// prefetch queue, applies EX redirects and stops on fetch faults.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/flush counters;
// without it both counter ports read zero and no counter flops exist.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned IMEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  fetch_state_e  state, state_nxt;
  fetch_fault_e  cause, cause_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          push, flush, pop, room, misalign, range_bad;

  assign pop       = o_valid && i_ready;
  assign room      = (count < CW'(QDEPTH)) || pop;
  assign misalign  = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign range_bad = ({2'b00, fetch_pc[31:2]} >= IMEM_WORDS);

  assign push_entry.pc   = fetch_pc;
  assign push_entry.inst = i_imem_rdata;

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk   (i_clk),
    .rst_n (i_reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .entry (push_entry),
    .count (count),
    .head  (head)
  );

  // Control state: FSM, fetch PC and the recorded fault cause.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      cause    <= F_NONE;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      cause    <= cause_nxt;
    end
  end

  // Next-state, PC update, push/flush decisions. A redirect always wins over
  // a push; the first fault seen moves to S_FAULT and nothing leaves it.
  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    case (state)
      S_BOOT: begin
        if (misalign) begin
          state_nxt = S_FAULT;
          cause_nxt = F_MISALIGN;
        end else begin
          // Queue is empty here, so a boot-time redirect only needs the PC.
          if (i_redirect) fetch_pc_nxt = i_redirect_pc;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (misalign) begin
          state_nxt = S_FAULT;
          cause_nxt = F_MISALIGN;
        end else if (i_redirect) begin
          flush        = 1'b1;
          fetch_pc_nxt = i_redirect_pc;
        end else if (room) begin
          if (range_bad) begin
            state_nxt = S_FAULT;
            cause_nxt = F_RANGE;
          end else begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + 32'(INST_BYTES);
          end
        end
      end
      default: ;
    endcase
  end

  assign o_imem_addr   = fetch_pc;
  assign o_valid       = (count != '0);
  assign o_pc          = o_valid ? head.pc   : 32'h0;
  assign o_inst        = o_valid ? head.inst : 32'h0;
  assign o_fault       = (state == S_FAULT);
  assign o_fault_cause = cause;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic        redir_acc;

  assign redir_acc = i_redirect && !misalign && (state != S_FAULT);

  // Saturating perf counters: decode back-pressure cycles and accepted redirects.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (o_valid && !i_ready && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (redir_acc && (flush_cnt != 32'hFFFF_FFFF))           flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;
`else
  assign o_stall_cnt = 32'h0;
  assign o_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a decode-side scoreboard tracks which PC must be
// delivered next, plus directed literal checks for each scenario.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, redirect, ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, o_pc, o_inst, stall_cnt, flush_cnt;
  logic        o_valid, o_fault;
  logic [1:0]  o_cause;

  logic        rst_n_r, redirect_r, ready_r;
  logic [31:0] redirect_pc_r;
  logic [31:0] imem_addr_r, imem_rdata_r, o_pc_r, o_inst_r, stall_cnt_r, flush_cnt_r;
  logic        o_valid_r, o_fault_r;
  logic [1:0]  o_cause_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h1300_0000 + a;
  endfunction

  function automatic logic [31:0] perf(input int v);
`ifdef FETCH_PERF_CNT_EN
    return 32'(v);
`else
    return 32'h0;
`endif
  endfunction

  assign imem_rdata   = imem_word(imem_addr);
  assign imem_rdata_r = imem_word(imem_addr_r);

  fetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(2), .IMEM_WORDS(2048)) dut (
    .i_clk(clk), .i_reset(rst_n), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_valid(o_valid), .i_ready(ready),
    .o_pc(o_pc), .o_inst(o_inst), .o_fault(o_fault), .o_fault_cause(o_cause),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  fetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(2), .IMEM_WORDS(16)) dut_r (
    .i_clk(clk), .i_reset(rst_n_r), .o_imem_addr(imem_addr_r), .i_imem_rdata(imem_rdata_r),
    .i_redirect(redirect_r), .i_redirect_pc(redirect_pc_r), .o_valid(o_valid_r), .i_ready(ready_r),
    .o_pc(o_pc_r), .o_inst(o_inst_r), .o_fault(o_fault_r), .o_fault_cause(o_cause_r),
    .o_stall_cnt(stall_cnt_r), .o_flush_cnt(flush_cnt_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: next PC decode must receive, sticky fault, perf event counts.
  logic [31:0] m_pc;
  logic        m_blank, m_fault;
  logic [1:0]  m_cause;
  int          m_stall, m_flush;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_blank = 1'b0; m_fault = 1'b0; m_cause = 2'd0;
      m_stall = 0; m_flush = 0;
    end else begin
      check("m_fault", 32'(o_fault), 32'(m_fault));
      check("m_cause", 32'(o_cause), 32'(m_cause));
      check("m_stall_cnt", stall_cnt, perf(m_stall));
      check("m_flush_cnt", flush_cnt, perf(m_flush));
      if (m_blank) check("m_valid_after_redirect", 32'(o_valid), 32'h0);
      if (o_valid && ready) begin
        check("m_pc", o_pc, m_pc);
        check("m_inst", o_inst, imem_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
      if (o_valid && !ready) m_stall++;
      m_blank = 1'b0;
      if (redirect && !m_fault) begin
        if (redirect_pc[1:0] != 2'b00) begin
          m_fault = 1'b1; m_cause = 2'd1;
        end else begin
          m_pc = redirect_pc; m_blank = 1'b1; m_flush++;
        end
      end
    end
  end

  initial begin
    int          n_r;
    logic [31:0] exp_r;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
    rst_n_r = 1'b0; redirect_r = 1'b0; redirect_pc_r = 32'h0; ready_r = 1'b1;
    step(); step();

    // Reset state
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_inst", o_inst, 32'h0);
    check("rst_fault", 32'(o_fault), 32'h0);
    check("rst_cause", 32'(o_cause), 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
    check("rst_flush_cnt", flush_cnt, 32'h0);

    // Scenario 1: boot idle cycle, then one instruction per cycle.
    // Counting the edge reset was released at, o_valid rises on the 3rd edge.
    rst_n = 1'b1;
    step();
    check("s1_valid_e2", 32'(o_valid), 32'h0);
    step();
    check("s1_valid_e3", 32'(o_valid), 32'h1);
    check("s1_pc0", o_pc, 32'h0);
    check("s1_inst0", o_inst, 32'h1300_0000);
    step();
    check("s1_pc4", o_pc, 32'h4);
    check("s1_inst4", o_inst, 32'h1300_0004);
    step();
    check("s1_pc8", o_pc, 32'h8);

    // Scenario 2: decode stalls 5 cycles with pc=8 at the head.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("s2_head_hold", o_pc, 32'h8);
    check("s2_addr_frozen", imem_addr, 32'h10);
    check("s2_stall_cnt", stall_cnt, perf(5));
    ready = 1'b1;
    step();
    check("s2_pc12", o_pc, 32'hC);
    step();
    check("s2_pc16", o_pc, 32'h10);
    step();

    // Scenario 3: redirect to 0x40 with the queue full.
    ready = 1'b0;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    check("s3_bubble", 32'(o_valid), 32'h0);
    check("s3_imem_addr", imem_addr, 32'h40);
    step();
    check("s3_valid", 32'(o_valid), 32'h1);
    check("s3_pc", o_pc, 32'h40);
    check("s3_inst", o_inst, 32'h1300_0040);
    check("s3_flush_cnt", flush_cnt, perf(1));
    ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Scenario 4: misaligned redirect faults; queue drains, fault sticks.
    ready = 1'b0;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    redirect = 1'b0;
    check("s4_fault", 32'(o_fault), 32'h1);
    check("s4_cause", 32'(o_cause), 32'h1);
    check("s4_still_valid", 32'(o_valid), 32'h1);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("s4_drained", 32'(o_valid), 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("s4_fault_hold", 32'(o_fault), 32'h1);
    check("s4_cause_hold", 32'(o_cause), 32'h1);
    check("s4_no_push", 32'(o_valid), 32'h0);

    // Scenario 6: restart, fill, fault, then async reset mid-cycle.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("s6_valid_e2", 32'(o_valid), 32'h0);
    step();
    check("s6_pc0", o_pc, 32'h0);
    step();
    check("s6_pc4", o_pc, 32'h4);
    ready = 1'b0;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0101;
    step();
    redirect = 1'b0;
    check("s6_fault", 32'(o_fault), 32'h1);
    check("s6_full_valid", 32'(o_valid), 32'h1);
    check("s6_stall_cnt", stall_cnt, perf(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_valid", 32'(o_valid), 32'h0);
    check("s6_async_fault", 32'(o_fault), 32'h0);
    check("s6_async_cause", 32'(o_cause), 32'h0);
    check("s6_async_pc", o_pc, 32'h0);
    check("s6_async_addr", imem_addr, 32'h0);
    check("s6_async_stall", stall_cnt, 32'h0);
    ready = 1'b1;
    step();

    // Scenario 5: 16-word memory; last delivered pc is 0x3C, then range fault.
    rst_n_r = 1'b1;
    n_r = 0;
    exp_r = 32'h0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_valid_r) begin
        check("s5_pc", o_pc_r, exp_r);
        check("s5_inst", o_inst_r, imem_word(exp_r));
        exp_r = exp_r + 32'd4;
        n_r++;
      end
    end
    check("s5_count", 32'(n_r), 32'd16);
    check("s5_last_pc", exp_r - 32'd4, 32'h3C);
    check("s5_fault", 32'(o_fault_r), 32'h1);
    check("s5_cause", 32'(o_cause_r), 32'h2);
    check("s5_valid_end", 32'(o_valid_r), 32'h0);
    check("s5_addr_hold", imem_addr_r, 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
